// File: rtl/ariane_pkg.sv
// ariane_pkg: shared constants and types for the performance-counter sampler.
package ariane_pkg;

    localparam logic [7:0]  SampleMagic  = 8'hA5;
    localparam int unsigned DroppedWidth = 16;

    typedef enum logic {
        IDLE,
        STREAM
    } sampler_state_e;

endpackage

// File: rtl/perf_sample_timer.sv
// perf_sample_timer: interval timer that emits a one-cycle request every interval_i cycles.
module perf_sample_timer #(
    parameter int unsigned IntervalWidth = 32
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     enable_i,
    input  logic [IntervalWidth-1:0] interval_i,
    output logic                     req_o
);

    logic [IntervalWidth-1:0] timer_q;
    logic                     active;

    assign active = enable_i && (interval_i != '0);
    // >= rather than == so that lowering interval_i mid-count still fires promptly
    assign req_o  = active && (timer_q >= interval_i - 1'b1);

    always_ff @(posedge clk_i) begin
        if (rst_i || !active || req_o) timer_q <= '0;
        else                           timer_q <= timer_q + 1'b1;
    end

endmodule

// File: rtl/perf_sampler.sv
// perf_sampler: snapshots the performance counters on a periodic or software request
// and streams them out as a header word followed by lo/hi halves of each counter.
module perf_sampler
    import ariane_pkg::*;
#(
    parameter int unsigned NumCounters   = 11,
    parameter int unsigned IntervalWidth = 32
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic [NumCounters-1:0][63:0] counters_i,
    input  logic                         enable_i,
    input  logic [IntervalWidth-1:0]     interval_i,
    input  logic                         trigger_i,
    output logic [31:0]                  data_o,
    output logic                         valid_o,
    input  logic                         ready_i,
    output logic                         last_o,
    output logic [DroppedWidth-1:0]      dropped_o,
    output logic                         busy_o
);

    localparam int unsigned NumWords = 2 * NumCounters + 1;
    localparam int unsigned IdxW     = $clog2(NumWords);
    localparam int unsigned SelW     = $clog2(NumCounters * 64);
    localparam logic [IdxW-1:0] LastIdx = IdxW'(NumWords - 1);

    sampler_state_e            state_q;
    logic [IdxW-1:0]           idx_q;
    logic [IdxW-1:0]           half_idx;
    logic [15:0]               seq_q;
    logic [DroppedWidth-1:0]   dropped_q;
    logic [NumCounters*64-1:0] snap_q;
    logic [SelW-1:0]           sel;
    logic [31:0]               word;
    logic                      tick;
    logic                      req;
    logic                      hs;
    logic                      hs_last;
    logic                      accept;

    perf_sample_timer #(
        .IntervalWidth(IntervalWidth)
    ) u_timer (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .enable_i  (enable_i),
        .interval_i(interval_i),
        .req_o     (tick)
    );

    assign req     = tick | trigger_i;
    assign hs      = valid_o && ready_i;
    assign hs_last = hs && (idx_q == LastIdx);
    // A request on the final handshake chains straight into the next sample
    assign accept  = req && ((state_q == IDLE) || hs_last);

    // Word 2k+1/2k+2 map to bit offset (2k+0/1)*32 of the flat snapshot
    assign half_idx = (idx_q == '0) ? '0 : idx_q - 1'b1;
    assign sel      = SelW'({half_idx, 5'd0});
    assign word     = (idx_q == '0) ? {seq_q, 8'(NumCounters), SampleMagic} : snap_q[sel +: 32];

    assign valid_o   = (state_q == STREAM);
    assign busy_o    = (state_q == STREAM);
    assign last_o    = valid_o && (idx_q == LastIdx);
    assign data_o    = valid_o ? word : '0;
    assign dropped_o = dropped_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            seq_q     <= '0;
            dropped_q <= '0;
        end else begin
            if (accept) begin
                state_q <= STREAM;
                idx_q   <= '0;
            end else if (hs_last) begin
                state_q <= IDLE;
                idx_q   <= '0;
            end else if (hs) begin
                idx_q <= idx_q + 1'b1;
            end
            if (hs_last) seq_q <= seq_q + 1'b1;
            if (req && !accept && (dropped_q != '1)) dropped_q <= dropped_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (accept) snap_q <= counters_i;
    end

endmodule

// File: tb/tb_perf_sampler.sv
// tb_perf_sampler: scoreboard bench for perf_sampler; expected words are queued when a
// sample request is driven and popped as the DUT hands each word off.
module tb_perf_sampler;

    localparam int N = 11;

    logic              clk_i = 1'b0;
    logic              rst_i = 1'b1;
    logic [N-1:0][63:0] cnt;
    logic              enable_i = 1'b0;
    logic [31:0]       interval_i = '0;
    logic              trigger_i = 1'b0;
    logic              ready_i = 1'b0;
    logic [31:0]       data_o;
    logic              valid_o;
    logic              last_o;
    logic [15:0]       dropped_o;
    logic              busy_o;

    logic [32:0] sb[$];
    logic [32:0] exp_w;
    logic [33:0] held;
    logic        stalled = 1'b0;
    logic [15:0] exp_seq = '0;
    int          exp_drop = 0;
    int          total = 0;
    int          bad = 0;

    always #5 clk_i = ~clk_i;

    perf_sampler #(
        .NumCounters  (N),
        .IntervalWidth(32)
    ) dut (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .counters_i(cnt),
        .enable_i  (enable_i),
        .interval_i(interval_i),
        .trigger_i (trigger_i),
        .data_o    (data_o),
        .valid_o   (valid_o),
        .ready_i   (ready_i),
        .last_o    (last_o),
        .dropped_o (dropped_o),
        .busy_o    (busy_o)
    );

    task automatic push_sample();
        sb.push_back({1'b0, exp_seq, 8'(N), 8'hA5});
        for (int k = 0; k < N; k++) begin
            sb.push_back({1'b0, cnt[k][31:0]});
            sb.push_back({(k == N - 1) ? 1'b1 : 1'b0, cnt[k][63:32]});
        end
        exp_seq = exp_seq + 16'd1;
    endtask

    // Observe at the falling edge, then return just after the next rising edge
    task automatic tick();
        @(negedge clk_i);
        if (!rst_i && stalled) begin
            total++;
            if ({valid_o, last_o, data_o} !== held) begin
                bad++;
                $display("FAIL stall_stable: got v=%b l=%b d=%h want v=%b l=%b d=%h",
                         valid_o, last_o, data_o, held[33], held[32], held[31:0]);
            end
        end
        if (!rst_i && valid_o && ready_i) begin
            total++;
            if (sb.size() == 0) begin
                bad++;
                $display("FAIL word: got unexpected l=%b d=%h want no word", last_o, data_o);
            end else begin
                exp_w = sb.pop_front();
                if ({last_o, data_o} !== exp_w) begin
                    bad++;
                    $display("FAIL word: got l=%b d=%h want l=%b d=%h",
                             last_o, data_o, exp_w[32], exp_w[31:0]);
                end
            end
        end
        stalled = !rst_i && valid_o && !ready_i;
        held    = {valid_o, last_o, data_o};
        @(posedge clk_i);
        #1;
    endtask

    task automatic drain(input string name);
        int i;
        for (i = 0; i < 3000 && (sb.size() != 0 || busy_o); i++) tick();
        total++;
        if (sb.size() != 0 || busy_o !== 1'b0) begin
            bad++;
            $display("FAIL %s_drain: got left=%0d busy=%b want left=0 busy=0", name, sb.size(), busy_o);
        end
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        tick();
        tick();
        total += 5;
        if (valid_o !== 1'b0) begin bad++; $display("FAIL rst_valid: got %b want 0", valid_o); end
        if (last_o !== 1'b0) begin bad++; $display("FAIL rst_last: got %b want 0", last_o); end
        if (busy_o !== 1'b0) begin bad++; $display("FAIL rst_busy: got %b want 0", busy_o); end
        if (data_o !== 32'h0) begin bad++; $display("FAIL rst_data: got %h want 0", data_o); end
        if (dropped_o !== 16'h0) begin bad++; $display("FAIL rst_dropped: got %h want 0", dropped_o); end
        rst_i = 1'b0;
        tick();
    endtask

    task automatic test_single_trigger();
        int n = 0;
        ready_i   = 1'b1;
        trigger_i = 1'b1;
        push_sample();
        tick();
        trigger_i = 1'b0;
        total++;
        if (valid_o !== 1'b1 || data_o !== 32'h00000BA5) begin
            bad++;
            $display("FAIL single_hdr: got v=%b d=%h want v=1 d=00000ba5", valid_o, data_o);
        end
        for (int i = 0; i < 100 && valid_o; i++) begin
            if (n == 1 || n == 2) begin
                total++;
                if (data_o !== ((n == 1) ? 32'h2 : 32'h1)) begin
                    bad++;
                    $display("FAIL single_w%0d: got %h want %h", n, data_o, (n == 1) ? 32'h2 : 32'h1);
                end
            end
            n++;
            tick();
        end
        total += 3;
        if (n != 23) begin bad++; $display("FAIL single_len: got %0d want 23", n); end
        if (sb.size() != 0) begin bad++; $display("FAIL single_left: got %0d want 0", sb.size()); end
        if (dropped_o !== 16'(exp_drop)) begin
            bad++;
            $display("FAIL single_dropped: got %0d want %0d", dropped_o, exp_drop);
        end
    endtask

    task automatic test_periodic();
        ready_i = 1'b1;
        push_sample();
        push_sample();
        enable_i   = 1'b1;
        interval_i = 32'd5;
        for (int i = 0; i < 50; i++) tick();
        enable_i = 1'b0;
        exp_drop += 8;
        drain("periodic");
        for (int i = 0; i < 10; i++) tick();
        total += 2;
        if (busy_o !== 1'b0) begin bad++; $display("FAIL periodic_idle: got busy=%b want 0", busy_o); end
        if (dropped_o !== 16'(exp_drop)) begin
            bad++;
            $display("FAIL periodic_dropped: got %0d want %0d", dropped_o, exp_drop);
        end
    endtask

    task automatic test_backpressure();
        int i;
        cnt[0] = 64'h0000_0000_FFFF_FFF0;
        for (i = 0; i < 1000; i++) begin
            tick();
            for (int k = 0; k < N; k++) cnt[k] = cnt[k] + 64'(k + 1);
            ready_i   = 1'($urandom_range(0, 1));
            trigger_i = (i == 3) || (i == 10);
            if (i == 3) push_sample();
            if (i == 10) exp_drop++;
            if (i > 12 && sb.size() == 0 && !busy_o) break;
        end
        ready_i = 1'b1;
        total += 2;
        if (i >= 1000) begin bad++; $display("FAIL bp_timeout: got left=%0d want 0", sb.size()); end
        if (dropped_o !== 16'(exp_drop)) begin
            bad++;
            $display("FAIL bp_dropped: got %0d want %0d", dropped_o, exp_drop);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] hdr;
        ready_i   = 1'b1;
        trigger_i = 1'b1;
        push_sample();
        tick();
        trigger_i = 1'b0;
        for (int i = 0; i < 22; i++) tick();
        total++;
        if (valid_o !== 1'b1 || last_o !== 1'b1) begin
            bad++;
            $display("FAIL b2b_last: got v=%b l=%b want v=1 l=1", valid_o, last_o);
        end
        for (int k = 0; k < N; k++) cnt[k] = {32'(k + 100), 32'hCAFE_0000 + 32'(k)};
        hdr       = {exp_seq, 8'(N), 8'hA5};
        trigger_i = 1'b1;
        push_sample();
        tick();
        trigger_i = 1'b0;
        total += 2;
        if (valid_o !== 1'b1 || data_o !== hdr) begin
            bad++;
            $display("FAIL b2b_hdr: got v=%b d=%h want v=1 d=%h", valid_o, data_o, hdr);
        end
        if (dropped_o !== 16'(exp_drop)) begin
            bad++;
            $display("FAIL b2b_dropped: got %0d want %0d", dropped_o, exp_drop);
        end
        drain("b2b");
    endtask

    task automatic test_drop_saturation();
        ready_i   = 1'b0;
        trigger_i = 1'b1;
        push_sample();
        tick();
        for (int j = 1; j <= 70000; j++) begin
            tick();
            if (j == 65534 - exp_drop) begin
                total++;
                if (dropped_o !== 16'hFFFE) begin
                    bad++;
                    $display("FAIL sat_fffe: got %h want fffe", dropped_o);
                end
            end
        end
        total++;
        if (dropped_o !== 16'hFFFF) begin bad++; $display("FAIL sat_hold: got %h want ffff", dropped_o); end
        trigger_i = 1'b0;
        ready_i   = 1'b1;
        exp_drop  = 65535;
        drain("sat");
    endtask

    task automatic test_reset_mid_stream();
        ready_i   = 1'b1;
        trigger_i = 1'b1;
        push_sample();
        tick();
        trigger_i = 1'b0;
        for (int i = 0; i < 7; i++) tick();
        total++;
        if (data_o !== cnt[3][31:0]) begin
            bad++;
            $display("FAIL rstmid_w7: got %h want %h", data_o, cnt[3][31:0]);
        end
        rst_i = 1'b1;
        tick();
        total++;
        if (valid_o !== 1'b0) begin bad++; $display("FAIL rstmid_valid: got %b want 0", valid_o); end
        sb.delete();
        tick();
        rst_i    = 1'b0;
        exp_seq  = '0;
        exp_drop = 0;
        total++;
        if (dropped_o !== 16'h0) begin bad++; $display("FAIL rstmid_dropped: got %h want 0", dropped_o); end
        trigger_i = 1'b1;
        push_sample();
        tick();
        trigger_i = 1'b0;
        total++;
        if (valid_o !== 1'b1 || data_o !== 32'h00000BA5) begin
            bad++;
            $display("FAIL rstmid_hdr: got v=%b d=%h want v=1 d=00000ba5", valid_o, data_o);
        end
        drain("rstmid");
    endtask

    initial begin
        for (int k = 0; k < N; k++) cnt[k] = {32'hA000_0000 + 32'(k), 32'h5000_0000 + 32'(k * 3)};
        cnt[0] = 64'h1_0000_0002;
        test_reset();
        test_single_trigger();
        test_periodic();
        test_backpressure();
        test_back_to_back();
        test_drop_saturation();
        test_reset_mid_stream();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/perf_sampler.md
PERF_SAMPLER -- requirements
Module: perf_sampler

Interface
REQ-001 The block SHALL have parameter NumCounters, default 11, meaning the number of 64-bit counters sampled (1..255).
REQ-002 The block SHALL have parameter IntervalWidth, default 32, meaning the width of the sampling interval.
REQ-003 The block SHALL have one clock and a synchronous, active-high reset.
REQ-004 The block SHALL have port clk_i, input, width 1, meaning the block clock; all state is updated on its rising edge.
REQ-005 The block SHALL have port rst_i, input, width 1, meaning the synchronous active-high reset.
REQ-006 The block SHALL have port counters_i, input, width NumCounters x 64, meaning the live counter values from the performance-counter block (index k = counter k+1).
REQ-007 The block SHALL have port enable_i, input, width 1, meaning periodic sampling is enabled.
REQ-008 The block SHALL have port interval_i, input, width IntervalWidth, meaning the sampling period in cycles; 0 disables periodic sampling.
REQ-009 The block SHALL have port trigger_i, input, width 1, meaning a one-cycle software sample request.
REQ-010 The block SHALL have port data_o, output, width 32, meaning the stream word.
REQ-011 The block SHALL have port valid_o, output, width 1, meaning data_o is valid.
REQ-012 The block SHALL have port ready_i, input, width 1, meaning the consumer accepts the word.
REQ-013 The block SHALL have port last_o, output, width 1, meaning the final word of a sample.
REQ-014 The block SHALL have port dropped_o, output, width 16, meaning the number of dropped sample requests.
REQ-015 The block SHALL have port busy_o, output, width 1, meaning a sample is being streamed.

Function
REQ-016 The interval timer SHALL increment each cycle while enable_i=1 and interval_i!=0, and SHALL be held at 0 otherwise.
REQ-017 A periodic request SHALL be raised when timer >= interval_i-1; the timer SHALL return to 0 in the same cycle (covers interval_i lowered mid-count).
REQ-018 A periodic request and trigger_i in the same cycle SHALL produce exactly one request.
REQ-019 The FSM SHALL have two states, IDLE and STREAM.
REQ-020 In IDLE, a request in cycle t SHALL snapshot all of counters_i at the end of cycle t, move to STREAM, and assert valid_o in cycle t+1.
REQ-021 The stream SHALL consist of 1+2*NumCounters words: word 0 is the header, word 2k+1 is snapshot[k][31:0], and word 2k+2 is snapshot[k][63:32].
REQ-022 The header SHALL be {seq[15:0], NumCounters[7:0], 8'hA5}; seq starts at 0, increments after each sample is emitted, and wraps 0xFFFF->0.
REQ-023 The word index SHALL advance only on valid_o && ready_i; data_o, valid_o and last_o SHALL be stable while valid_o && !ready_i.
REQ-024 last_o SHALL be 1 only on word 2*NumCounters.
REQ-025 On the handshake of the last word, the FSM SHALL return to IDLE, unless a request is present in that same cycle.
REQ-026 If a request is present in the cycle of the last-word handshake, it SHALL be accepted back-to-back: a new snapshot is taken and valid_o stays 1 with the new header.
REQ-027 Any other request arriving in STREAM SHALL be dropped; dropped_o SHALL increment and saturate at 0xFFFF.
REQ-028 Deasserting enable_i or changing interval_i during STREAM SHALL NOT abort the current stream.
REQ-029 busy_o SHALL equal (state==STREAM).
REQ-030 The snapshot SHALL be unaffected by counter changes after the capture cycle.

Reset
REQ-031 While rst_i=1 at a clock edge, the block SHALL set state=IDLE, timer=0, seq=0, word index=0 and dropped_o=0.
REQ-032 The reset values of the outputs SHALL be valid_o=0, last_o=0, busy_o=0 and data_o=0.
REQ-033 Reset asserted mid-stream SHALL abandon the stream immediately, with no further valid words.
REQ-034 The snapshot registers SHALL have no reset requirement.

Structure
REQ-035 The header magic (8'hA5), the FSM state enum and the dropped-counter width SHALL be placed in ariane_pkg.
REQ-036 The interval timer SHALL be a sub-module perf_sample_timer (inputs: enable, interval; output: one-cycle request pulse).
REQ-037 The FSM, snapshot and word multiplexer SHALL remain in perf_sampler.

Verification
REQ-038 Trigger with enable_i=0, ready_i=1, counters_i[0]=64'h1_0000_0002 -> valid_o from the next cycle for 23 consecutive words: word 0=32'h00000BA5, word 1=2, word 2=1; last_o on word 22; seq becomes 1.
REQ-039 enable_i=1, interval_i=5, ready_i=1 -> headers at 5-cycle spacing are impossible (a stream takes 23 cycles): 1 sample per stream, and dropped_o increments on each intervening request.
REQ-040 ready_i toggling 0/1 randomly -> each word is held stable until accepted; word order and count are unchanged; the snapshot matches the counter values at the capture cycle despite counters incrementing.
REQ-041 Trigger driven in the cycle of the last-word handshake -> valid_o does not drop; the next header carries seq+1; dropped_o is unchanged.
REQ-042 dropped_o preloaded near 0xFFFF via 70000 dropped requests -> dropped_o holds at 0xFFFF.
REQ-043 rst_i=1 during word 7 -> valid_o=0 on the next cycle; after release, a trigger yields a header with seq=0.
